// File: rtl/pulse_stretcher_if.sv
// Event-in / stretched-level-out signal bundle for pulse_stretcher.
// No storage; pure wiring between the event source and the stretcher.
// No backpressure: events are accepted every cycle, and excess events are reported through overflow.
interface pulse_stretcher_if #(
  parameter int PEND_W = 4
) ();
  logic              pulse_in;
  logic              clear;
  logic              level_out;
  logic              busy;
  logic [PEND_W-1:0] pending;
  logic              overflow;

  // Event source / observer side
  modport master (
    output pulse_in,
    output clear,
    input  level_out,
    input  busy,
    input  pending,
    input  overflow
  );

  // Stretcher side
  modport slave (
    input  pulse_in,
    input  clear,
    output level_out,
    output busy,
    output pending,
    output overflow
  );
endinterface

// File: rtl/pulse_stretcher.sv
// Stretches each input event into a HIGH_CYCLES-wide level, with at least GAP_CYCLES low cycles between levels.
// Latency: level_out rises 1 cycle after the event is sampled. Events arriving during HIGH/GAP are queued and replayed in order.
// No backpressure: when the pending counter is saturated, a new event is dropped and overflow strobes for one cycle.
module pulse_stretcher #(
  parameter int HIGH_CYCLES = 4,
  parameter int GAP_CYCLES  = 2,
  parameter int PEND_W      = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  pulse_stretcher_if.slave   bus
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HIGH = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

  localparam logic [7:0]        HIGH_LOAD = 8'(HIGH_CYCLES - 1);
  localparam logic [7:0]        GAP_LOAD  = 8'(GAP_CYCLES - 1);
  localparam logic [PEND_W-1:0] PEND_MAX  = '1;
  localparam logic [PEND_W-1:0] PEND_ONE  = {{(PEND_W-1){1'b0}}, 1'b1};

  state_t            state_q, state_d;
  logic [7:0]        cnt_q, cnt_d;
  logic [PEND_W-1:0] pend_q, pend_d;
  logic              level_q, level_d;
  logic              busy_q, busy_d;
  logic              ovf_q, ovf_d;
  logic              enq;

  // Next-state, counter, pending-queue and output decode
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pend_d  = pend_q;
    ovf_d   = 1'b0;
    enq     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (bus.pulse_in) begin
          state_d = ST_HIGH;
          cnt_d   = HIGH_LOAD;
        end
      end
      ST_HIGH: begin
        enq = bus.pulse_in;
        if (cnt_q == 8'd0) begin
          state_d = ST_GAP;
          cnt_d   = GAP_LOAD;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      ST_GAP: begin
        if (cnt_q == 8'd0) begin
          if ((pend_q != '0) || bus.pulse_in) begin
            // Restart directly from GAP: a fresh pulse is consumed in place of
            // a queued one, so pending only drops when no new pulse arrives.
            state_d = ST_HIGH;
            cnt_d   = HIGH_LOAD;
            if ((pend_q != '0) && !bus.pulse_in) begin
              pend_d = pend_q - PEND_ONE;
            end
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          enq   = bus.pulse_in;
          cnt_d = cnt_q - 8'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = 8'd0;
      end
    endcase

    if (enq) begin
      if (pend_q != PEND_MAX) begin
        pend_d = pend_q + PEND_ONE;
      end else begin
        ovf_d = 1'b1;
      end
    end

    // Synchronous abort wins over any event in the same cycle
    if (bus.clear) begin
      state_d = ST_IDLE;
      cnt_d   = 8'd0;
      pend_d  = '0;
      ovf_d   = 1'b0;
    end

    level_d = (state_d == ST_HIGH);
    busy_d  = (state_d != ST_IDLE);
  end

  // State and registered outputs, cleared asynchronously by reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= 8'd0;
      pend_q  <= '0;
      level_q <= 1'b0;
      busy_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      level_q <= level_d;
      busy_q  <= busy_d;
      ovf_q   <= ovf_d;
    end
  end

  assign bus.level_out = level_q;
  assign bus.busy      = busy_q;
  assign bus.pending   = pend_q;
  assign bus.overflow  = ovf_q;

endmodule

// File: doc/pulse_stretcher.md
PULSE_STRETCHER -- requirements
Module: pulse_stretcher

Interface
REQ-001 SHALL provide parameter HIGH_CYCLES, default 4: cycles level_out is held high per event; legal range 1..255.
REQ-002 SHALL provide parameter GAP_CYCLES, default 2: minimum low cycles between consecutive stretched outputs; legal range 1..255.
REQ-003 SHALL provide parameter PEND_W, default 4: pending-event counter width; the counter saturates at 2^PEND_W-1.
REQ-004 SHALL have port clk, input, 1 bit: single clock; all state updates on the rising edge.
REQ-005 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have port pulse_in, input, 1 bit: event strobe, typically a one-cycle pulse from the button debouncer; every cycle it is high counts as one event.
REQ-007 SHALL have port clear, input, 1 bit: synchronous abort of all activity.
REQ-008 SHALL have port level_out, output, 1 bit: registered stretched level, for example an LED or a downstream enable.
REQ-009 SHALL have port busy, output, 1 bit: registered; high whenever state is not IDLE.
REQ-010 SHALL have port pending, output, PEND_W bits: registered count of queued, not-yet-replayed events.
REQ-011 SHALL have port overflow, output, 1 bit: registered one-cycle strobe raised when an event is dropped.

Function
REQ-012 SHALL implement the FSM states IDLE, HIGH and GAP, with a down-counter of 8 bits or more.
REQ-013 SHALL, in IDLE with pulse_in=1, enter HIGH and load the counter with HIGH_CYCLES-1; level_out rises on the next cycle, so latency is 1 cycle.
REQ-014 SHALL hold level_out=1 for exactly HIGH_CYCLES cycles in HIGH; when the counter reaches 0, the FSM enters GAP and loads GAP_CYCLES-1.
REQ-015 SHALL hold level_out=0 for exactly GAP_CYCLES cycles in GAP; on the last GAP cycle:
- if an event is available (pending>0 or pulse_in=1), the FSM enters HIGH directly, with no IDLE cycle;
- otherwise it enters IDLE.
REQ-016 SHALL, when pulse_in=1 in HIGH or GAP (other than a pulse consumed per REQ-015), increment pending if pending < max.
- If pending = max, the event is dropped and overflow=1 on the next cycle.
REQ-017 SHALL leave pending unchanged when a dequeue (REQ-015 with pending>0) and a new pulse_in occur in the same cycle; no drop occurs at saturation in that case.
REQ-018 SHALL, when the last GAP cycle has pending=0 and pulse_in=1, restart HIGH with pending left at 0.
REQ-019 SHALL decrement pending by 1 on each dequeue from pending.
REQ-020 SHALL, on clear=1, go to IDLE on the next cycle with level_out=0, pending=0, overflow=0 and busy=0; clear overrides pulse_in in the same cycle.
REQ-021 SHALL keep all outputs glitch-free, because every output is driven directly from a flop.

Reset
REQ-022 SHALL, while rst_n=0, force immediately, independent of clk: state=IDLE, counter=0, level_out=0, busy=0, pending=0, overflow=0.
REQ-023 SHALL, after rst_n deasserts, leave the block idle until the first sampled pulse_in; reset asserted mid-HIGH or mid-GAP discards all queued events.

Verification (HIGH_CYCLES=4, GAP_CYCLES=2, PEND_W=2 unless stated; cycle n = edge n)
REQ-024 SHALL cover: single pulse_in at cycle 0 -> level_out=1 in cycles 1-4 and 0 in cycles 5-6; busy=1 in cycles 1-6; IDLE and busy=0 at cycle 7.
REQ-025 SHALL cover: pulses at cycles 0, 1, 2 -> pending=1 then 2; level_out high in cycles 1-4, 7-10 and 13-16; pending 1 at cycle 7 and 0 at cycle 13; busy=0 at cycle 19.
REQ-026 SHALL cover: pulse_in held high for cycles 0-4 -> pending saturates at 3 by cycle 4; the cycle-4 event is dropped; overflow=1 only in cycle 5; exactly 4 stretched pulses follow.
REQ-027 SHALL cover: pending=0 with pulse_in on the final GAP cycle -> level_out rises the next cycle, no IDLE cycle, pending stays 0; repeat at pending=3 -> pending stays 3 and overflow stays 0.
REQ-028 SHALL cover: rst_n pulled low mid-HIGH with pending=2 -> level_out and pending go to 0 asynchronously before the next edge; after release, no output without a new pulse.
REQ-029 SHALL cover: clear=1 together with pulse_in during GAP with pending=1 -> next cycle IDLE, pending=0, level_out=0, busy=0.
